// File: rtl/iob_2p_ram_rdr_if.sv
// iob_2p_ram_rdr_if
//   Bundles the two data paths of the read engine: the RAM read port
//   and the outgoing valid/ready word stream.
//
//   master modport (engine side):
//     r_en      out : RAM read enable
//     r_addr    out : RAM read address
//     r_data    in  : RAM read data, valid the cycle after r_en
//     out_valid out : stream word available
//     out_ready in  : consumer accepts word
//     out_data  out : stream word
//   slave modport is the mirror image (RAM model + consumer side).
//
//   Stream handshake: a word moves when out_valid and out_ready are both
//   high at a rising edge; once out_valid is high, out_valid and out_data
//   stay unchanged until that handshake happens.
interface iob_2p_ram_rdr_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              r_en;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output r_en, r_addr, out_valid, out_data,
      input  r_data, out_ready
   );

   modport slave (
      input  r_en, r_addr, out_valid, out_data,
      output r_data, out_ready
   );
endinterface

// File: rtl/iob_2p_ram_rdr.sv
// iob_2p_ram_rdr
//   Read-side streaming engine for a 2-port RAM. A start command reads a
//   contiguous address range through the RAM read port and presents the
//   words on a valid/ready stream, one word per cycle when not stalled.
//   The RAM's 1-cycle read latency is absorbed by a 2-entry FIFO; the
//   in-flight word is shown directly on the stream while the FIFO is empty.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     start      : command strobe (ignored while busy)
//     start_addr : first address, sampled with start
//     len        : word count (0 = no-op, clipped to 2**ADDR_W)
//     busy       : transfer in progress
//     done       : one-cycle pulse when the transfer finishes
//     err        : range overflow flag
//     state_dbg  : current FSM state (debug)
//     bus        : RAM read port + output stream (master modport)
//
//   Build option IOB_2P_RAM_RDR_WRAP_EN:
//     defined     : ranges past the top address wrap to 0, err tied 0
//     not defined : ranges are truncated at the top address and err is set
//                   with the done pulse, held until the next accepted start
module iob_2p_ram_rdr #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        state_dbg,
   iob_2p_ram_rdr_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;       // next address to issue
   logic [ADDR_W-1:0] last_addr_q;  // last issued address, shown while idle
   logic [ADDR_W:0]   remain_q;     // reads still to issue
   logic              inflight_q;   // a read was issued last cycle
   logic [DATA_W-1:0] mem_q [2];
   logic              rd_ptr_q, wr_ptr_q;
   logic [1:0]        cnt_q;
   logic              done_q;

   logic              head_valid, pop, pop_buf, push, issue, accept, done_d;
   logic [2:0]        occ;
   logic [ADDR_W:0]   len_clip, len_eff;

   // ---------------- command length handling ----------------
`ifdef IOB_2P_RAM_RDR_WRAP_EN
   always_comb begin
      len_clip = (len > DEPTH) ? DEPTH : len;
      len_eff  = len_clip;
   end
   assign err = 1'b0;
`else
   logic            trunc, trunc_q, err_q;
   logic [ADDR_W:0] room;

   always_comb begin
      len_clip = (len > DEPTH) ? DEPTH : len;
      room     = DEPTH - {1'b0, start_addr};
      trunc    = ({2'b00, start_addr} + {1'b0, len}) > {1'b0, DEPTH};
      len_eff  = trunc ? room : len_clip;
   end
   assign err = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         trunc_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept) begin
         trunc_q <= trunc;
         err_q   <= 1'b0;
      end else if (done_d && trunc_q) begin
         err_q   <= 1'b1;
      end
   end
`endif

   // ---------------- output buffer ----------------
   // The stream head is the oldest FIFO entry, or the in-flight word when
   // the FIFO is empty. An in-flight word consumed directly is not stored.
   always_comb begin
      head_valid    = (cnt_q != 2'd0);
      bus.out_valid = head_valid | inflight_q;
      if (head_valid)      bus.out_data = mem_q[rd_ptr_q];
      else if (inflight_q) bus.out_data = bus.r_data;
      else                 bus.out_data = '0;
      pop     = bus.out_valid & bus.out_ready;
      pop_buf = pop & head_valid;
      push    = inflight_q & ~(pop & ~head_valid);
      // words held after this cycle, before any new issue
      occ     = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      accept  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (len_eff != '0) state_d = S_READ;
               else               done_d  = 1'b1;
            end
         end
         S_READ: begin
            if (occ < 3'd2) begin
               issue = 1'b1;
               if (remain_q == ONE) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (occ == 3'd0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         last_addr_q <= '0;
         remain_q    <= '0;
         inflight_q  <= 1'b0;
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         inflight_q <= issue;
         if (accept) begin
            addr_q   <= start_addr;
            remain_q <= len_eff;
         end
         if (issue) begin
            addr_q      <= addr_q + 1'b1;
            last_addr_q <= addr_q;
            remain_q    <= remain_q - ONE;
         end
         if (push) begin
            mem_q[wr_ptr_q] <= bus.r_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_buf) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop_buf};
      end
   end

   assign bus.r_en   = issue;
   assign bus.r_addr = issue ? addr_q : last_addr_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_iob_2p_ram_rdr.sv
`timescale 1ns/1ps
module tb_iob_2p_ram_rdr;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              start = 1'b0;
   logic [ADDR_W-1:0] start_addr = '0;
   logic [ADDR_W:0]   len = '0;
   logic              busy, done, err;
   logic [1:0]        state_dbg;

   iob_2p_ram_rdr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   iob_2p_ram_rdr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .start_addr(start_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .state_dbg (state_dbg),
      .bus       (bus)
   );

   // RAM model: data = addr + 32, one-cycle read latency
   logic [DATA_W-1:0] ram [16];
   initial for (int i = 0; i < 16; i++) ram[i] = 8'(i + 32);
   always @(posedge clk) if (bus.r_en) bus.r_data <= ram[bus.r_addr];

   // ---------------- scoreboard state ----------------
   logic [DATA_W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int sc = 0;
   int ren_cnt, rcv_cnt, done_cnt, busy_cnt;
   int first_ren, first_valid, last_ren, done_cyc;
   logic [ADDR_W-1:0] addr_base = '0;
   logic [ADDR_W-1:0] last_addr = '0;
   bit                prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;

   // Stream / read-port monitor, sampled on the falling edge
   always @(negedge clk) begin
      logic [DATA_W-1:0] e;
      cyc++;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (bus.out_valid && first_valid < 0) first_valid = cyc;
         checks++;
         if (bus.r_en) begin
            if (first_ren < 0) first_ren = cyc;
            last_ren = cyc;
            if (bus.r_addr !== 4'(int'(addr_base) + ren_cnt) || !busy) begin
               errors++;
               $display("FAIL r_addr_issue: got addr %0d busy %0b, expected addr %0d busy 1",
                        bus.r_addr, busy, 4'(int'(addr_base) + ren_cnt));
            end
            last_addr = bus.r_addr;
            ren_cnt++;
         end else if (bus.r_addr !== last_addr) begin
            errors++;
            $display("FAIL r_addr_hold: got %0d expected %0d", bus.r_addr, last_addr);
         end
         if (prev_stall) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
               errors++;
               $display("FAIL stall_hold: got valid %0b data %0d expected valid 1 data %0d",
                        bus.out_valid, bus.out_data, prev_data);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            rcv_cnt++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got %0d expected no word", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin
                  errors++;
                  $display("FAIL word: got %0d expected %0d", bus.out_data, e);
               end
            end
         end
         checks++;
         if (ren_cnt - rcv_cnt > 2) begin
            errors++;
            $display("FAIL outstanding: got %0d reads ahead expected at most 2", ren_cnt - rcv_cnt);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_counters();
      ren_cnt = 0; rcv_cnt = 0; done_cnt = 0; busy_cnt = 0;
      first_ren = -1; first_valid = -1; last_ren = -1; done_cyc = -1;
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] l, input bit now);
      if (!now) begin @(posedge clk); #1; end
      clear_counters();
      addr_base  = sa;
      start      = 1'b1;
      start_addr = sa;
      len        = l;
      @(posedge clk);
      sc = cyc;
      #1 start = 1'b0;
   endtask

   // mode 0: out_ready held 1; 1: random; 2: stall 5 cycles after 2nd word, then random
   task automatic run_xfer(input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] l, input int mode,
                           input int busy_start_at, input bit now, input bit chain);
      int n;
      bit e_err;
      int stall_left;
      bit stalled_once;
      n = (l > 16) ? 16 : int'(l);
      e_err = 1'b0;
`ifndef IOB_2P_RAM_RDR_WRAP_EN
      if (int'(sa) + int'(l) > 16) begin
         n = 16 - int'(sa);
         e_err = 1'b1;
      end
`endif
      exp_q.delete();
      for (int k = 0; k < n; k++) exp_q.push_back(8'((int'(sa) + k) % 16 + 32));
      bus.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pulse_start(sa, l, now);
      @(negedge clk); #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got %0b expected 0", err);
      end
      stall_left = 0;
      stalled_once = 1'b0;
      for (int i = 0; i < 300 && done_cnt == 0; i++) begin
         @(posedge clk); #1;
         start = (i == busy_start_at);
         if (start) begin start_addr = 4'd9; len = 5'd3; end
         if (mode == 0) bus.out_ready = 1'b1;
         else if (mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
         else begin
            if (!stalled_once && rcv_cnt >= 2) begin stalled_once = 1'b1; stall_left = 5; end
            if (stall_left > 0) begin bus.out_ready = 1'b0; stall_left--; end
            else if (stalled_once) bus.out_ready = 1'($urandom_range(0, 1));
            else bus.out_ready = 1'b1;
         end
         @(negedge clk); #1;
      end
      start = 1'b0;
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL done_seen: got %0d pulses expected 1", done_cnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_at_done: got %0b expected 0", busy);
      end
      checks++;
      if (err !== e_err) begin
         errors++;
         $display("FAIL err_at_done: got %0b expected %0b", err, e_err);
      end
      if (!chain) begin
         repeat (3) @(negedge clk);
         #1;
         checks++;
         if (done_cnt != 1 || err !== e_err) begin
            errors++;
            $display("FAIL done_after: got %0d pulses err %0b expected 1 pulse err %0b",
                     done_cnt, err, e_err);
         end
      end
      checks++;
      if (rcv_cnt != n || exp_q.size() != 0) begin
         errors++;
         $display("FAIL word_count: got %0d words expected %0d", rcv_cnt, n);
      end
      checks++;
      if (ren_cnt != n) begin
         errors++;
         $display("FAIL ren_count: got %0d expected %0d", ren_cnt, n);
      end
      if (n == 0) begin
         checks++;
         if (busy_cnt != 0 || first_valid != -1 || done_cyc != sc + 1) begin
            errors++;
            $display("FAIL len0: got busy %0d valid_at %0d done_at %0d expected 0 -1 %0d",
                     busy_cnt, first_valid, done_cyc, sc + 1);
         end
      end else if (mode == 0) begin
         checks++;
         if (first_ren != sc + 1 || first_valid != sc + 2) begin
            errors++;
            $display("FAIL latency: got ren_at %0d valid_at %0d expected %0d %0d",
                     first_ren, first_valid, sc + 1, sc + 2);
         end
         checks++;
         if (last_ren - first_ren + 1 != n || done_cyc != sc + n + 2) begin
            errors++;
            $display("FAIL throughput: got ren_span %0d done_at %0d expected %0d %0d",
                     last_ren - first_ren + 1, done_cyc, n, sc + n + 2);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      clear_counters();
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({busy, done, err, bus.r_en, bus.out_valid} !== 5'b0 ||
          bus.r_addr !== 4'd0 || bus.out_data !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: got busy %0b done %0b err %0b r_en %0b r_addr %0d valid %0b data %0d expected all 0",
                  busy, done, err, bus.r_en, bus.r_addr, bus.out_valid, bus.out_data);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_full_range();
      run_xfer(4'd0, 5'd16, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_xfer(4'd3, 5'd6, 2, -1, 1'b0, 1'b0);
   endtask

   task automatic test_range_end();
      run_xfer(4'd14, 5'd4, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_len_zero();
      run_xfer(4'd7, 5'd0, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b1;
      exp_q.delete();
      for (int k = 0; k < 10; k++) exp_q.push_back(8'(k + 32));
      pulse_start(4'd0, 5'd10, 1'b0);
      for (int i = 0; i < 100 && rcv_cnt < 3; i++) begin
         @(negedge clk); #1;
      end
      checks++;
      if (rcv_cnt != 3) begin
         errors++;
         $display("FAIL reset_mid_words: got %0d expected 3", rcv_cnt);
      end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      last_addr = '0;
      clear_counters();
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || bus.r_en !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_clear: got busy %0b r_en %0b valid %0b done %0b expected 0 0 0 0",
                  busy, bus.r_en, bus.out_valid, done);
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL reset_mid_done: got %0d pulses expected 0", done_cnt);
      end
      run_xfer(4'd5, 5'd2, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_busy_start();
      run_xfer(4'd2, 5'd8, 0, 2, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_xfer(4'd0, 5'd3, 0, -1, 1'b0, 1'b1);
      run_xfer(4'd8, 5'd1, 0, -1, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 20; t++) begin
         run_xfer(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)), 1, -1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      bus.out_ready = 1'b1;
      clear_counters();
      test_reset();
      test_full_range();
      test_backpressure();
      test_range_end();
      test_len_zero();
      test_reset_mid();
      test_busy_start();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
